// File: rtl/pmem_stream_loader_if.sv
// Stream-in / program-memory-write bundle for pmem_stream_loader.
// master is the loader's view; slave is the byte source / memory side.
interface pmem_stream_loader_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 12
);
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic [ADDR_W-1:0]  pmem_addr;
    logic [INSTR_W-1:0] pmem_wdata;
    logic               pmem_we;

    modport master (
        input  in_data, in_valid,
        output in_ready, pmem_addr, pmem_wdata, pmem_we
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, pmem_addr, pmem_wdata, pmem_we
    );
endinterface

// File: rtl/pmem_stream_loader.sv
// LOAD-stage producer: unpacks a framed byte stream (count, hi/lo pairs,
// XOR checksum) into 12-bit program-memory writes and reports done/error.
module pmem_stream_loader #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned INSTR_W    = 12,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    pmem_stream_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    // Word counter must hold 2**ADDR_W and any 8-bit count byte.
    localparam int unsigned CW = ((ADDR_W > 8) ? ADDR_W : 8) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_HI, S_LO, S_CHK, S_DONE, S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [7:0]         xor_q, xor_d;
    logic [7:0]         hi_q, hi_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      num_q, num_d;

    logic               ready;
    logic               xfer;
    logic [CW-1:0]      cnt_inc;

    assign ready   = (state_q == S_HDR) || (state_q == S_HI) ||
                     (state_q == S_LO)  || (state_q == S_CHK);
    assign xfer    = ready && bus.in_valid;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        xor_d   = xor_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        num_d   = num_q;

        // Address advances in the cycle after each strobe.
        if (we_q) begin
            addr_d = addr_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    addr_d  = ADDR_W'(START_ADDR);
                    xor_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    num_d   = (bus.in_data == 8'h00) ? (CW'(1) << ADDR_W)
                                                     : CW'(bus.in_data);
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = bus.in_data;
                    xor_d   = xor_q ^ bus.in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    if (bus.in_data[7:4] != 4'h0) begin
                        state_d = S_ERR;
                    end else begin
                        xor_d   = xor_q ^ bus.in_data;
                        wdata_d = INSTR_W'({hi_q, bus.in_data[3:0]});
                        we_d    = 1'b1;
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == num_q) ? S_CHK : S_HI;
                    end
                end
            end
            S_CHK: begin
                if (xfer) begin
                    state_d = (bus.in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                busy_d  = 1'b0;
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            addr_q  <= ADDR_W'(START_ADDR);
            wdata_q <= '0;
            we_q    <= 1'b0;
            xor_q   <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            xor_q   <= xor_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.pmem_addr  = addr_q;
    assign bus.pmem_wdata = wdata_q;
    assign bus.pmem_we    = we_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
endmodule

// File: tb/tb_pmem_stream_loader.sv
// Directed self-checking bench for pmem_stream_loader: good/bad checksum,
// bad lo nibble, full-depth load, stalled stream, and mid-load reset.
module tb_pmem_stream_loader;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done, error;

    pmem_stream_loader_if #(.ADDR_W(8), .INSTR_W(12)) bus ();

    pmem_stream_loader #(
        .ADDR_W     (8),
        .INSTR_W    (12),
        .START_ADDR (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned consec   = 0;
    logic        prev_we  = 1'b0;
    logic [7:0]  wa[$];
    logic [11:0] wd[$];
    int unsigned wc[$];
    logic [7:0]  frame[$];

    always @(posedge clk) cyc++;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.pmem_we) begin
            wa.push_back(bus.pmem_addr);
            wd.push_back(bus.pmem_wdata);
            wc.push_back(cyc);
            if (prev_we) consec++;
        end
        prev_we = bus.pmem_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int unsigned guard = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check("ready_timeout", guard, 0);
        @(negedge clk);
    endtask

    task automatic send_frame(input bit gapped);
        int unsigned gaps[5] = '{0, 2, 1, 0, 3};
        for (int i = 0; i < frame.size(); i++) begin
            if (gapped && gaps[i % 5] != 0) begin
                bus.in_valid = 1'b0;
                repeat (gaps[i % 5]) @(negedge clk);
            end
            if (gapped && i == 2) begin
                bus.in_valid = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(frame[i]);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned guard = 0;
        while (busy && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check(tag, (guard < 2000), 1);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        consec = 0;
    endtask

    task automatic load_t1_frame(input logic [7:0] csum);
        frame = '{8'h02, 8'hA1, 8'h05, 8'h3C, 8'h07, csum};
    endtask

    initial begin
        int unsigned bad_a, bad_d, bad_gap;
        logic [7:0]  x;
        int unsigned t_lo;

        rst_n        = 1'b0;
        start        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_in_ready", bus.in_ready, 0);
        check("rst_addr",     bus.pmem_addr, 0);
        check("rst_wdata",    bus.pmem_wdata, 0);
        check("rst_we",       bus.pmem_we, 0);
        check("rst_flags",    {busy, done, error}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        // Bytes offered in IDLE are not taken.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(negedge clk);
        check("idle_no_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;

        // Good two-word frame.
        clear_log();
        pulse_start();
        check("t1_busy", busy, 1);
        frame = '{8'h02, 8'hA1, 8'h05};
        send_frame(1'b0);
        t_lo = cyc;
        bus.in_valid = 1'b1;
        frame = '{8'h3C, 8'h07, 8'h9F};
        send_frame(1'b0);
        wait_idle("t1_wait");
        check("t1_nwr",   wa.size(), 2);
        check("t1_a0",    wa[0], 8'h00);
        check("t1_d0",    wd[0], 12'hA15);
        check("t1_a1",    wa[1], 8'h01);
        check("t1_d1",    wd[1], 12'h3C7);
        check("t1_lat",   wc[0], t_lo);
        check("t1_gap",   wc[1] - wc[0], 2);
        check("t1_addr",  bus.pmem_addr, 8'h02);
        check("t1_flags", {busy, done, error}, 3'b010);

        // Same frame, wrong checksum.
        clear_log();
        pulse_start();
        check("t2_clr", {busy, done, error}, 3'b100);
        load_t1_frame(8'h00);
        send_frame(1'b0);
        wait_idle("t2_wait");
        check("t2_nwr",   wa.size(), 2);
        check("t2_d1",    wd[1], 12'h3C7);
        check("t2_flags", {busy, done, error}, 3'b001);

        // Non-zero upper nibble in lo byte.
        clear_log();
        pulse_start();
        frame = '{8'h01, 8'hFF, 8'h1F};
        send_frame(1'b0);
        @(negedge clk);
        check("t3_flags", {busy, done, error}, 3'b001);
        check("t3_ready", bus.in_ready, 0);
        repeat (2) @(negedge clk);
        check("t3_nwr",   wa.size(), 0);

        // Full-depth load, continuous stream.
        clear_log();
        frame.delete();
        frame.push_back(8'h00);
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            frame.push_back(8'(i) ^ 8'h5A);
            frame.push_back(8'(i) & 8'h0F);
            x = x ^ (8'(i) ^ 8'h5A) ^ (8'(i) & 8'h0F);
        end
        frame.push_back(x);
        pulse_start();
        send_frame(1'b0);
        wait_idle("t4_wait");
        bad_a = 0; bad_d = 0; bad_gap = 0;
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] !== 8'(i)) bad_a++;
            if (wd[i] !== {8'(i) ^ 8'h5A, 4'(i)}) bad_d++;
            if (i > 0 && (wc[i] - wc[i-1]) != 2) bad_gap++;
        end
        check("t4_nwr",    wa.size(), 256);
        check("t4_addrs",  bad_a, 0);
        check("t4_data",   bad_d, 0);
        check("t4_spacing", bad_gap, 0);
        check("t4_consec", consec, 0);
        check("t4_wrap",   bus.pmem_addr, 8'h00);
        check("t4_flags",  {busy, done, error}, 3'b010);

        // Stalled stream with an ignored start mid-frame.
        clear_log();
        pulse_start();
        load_t1_frame(8'h9F);
        send_frame(1'b1);
        wait_idle("t5_wait");
        check("t5_nwr",   wa.size(), 2);
        check("t5_a0",    wa[0], 8'h00);
        check("t5_d0",    wd[0], 12'hA15);
        check("t5_a1",    wa[1], 8'h01);
        check("t5_d1",    wd[1], 12'h3C7);
        check("t5_flags", {busy, done, error}, 3'b010);

        // Reset after the first word lands.
        clear_log();
        pulse_start();
        frame = '{8'h02, 8'hA1, 8'h05};
        send_frame(1'b0);
        @(negedge clk);
        bus.in_data  = 8'h3C;
        bus.in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_ready", bus.in_ready, 0);
        check("t6_rst_addr",  bus.pmem_addr, 0);
        check("t6_rst_wdata", bus.pmem_wdata, 0);
        check("t6_rst_we",    bus.pmem_we, 0);
        check("t6_rst_flags", {busy, done, error}, 3'b000);
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_nwr", wa.size(), 1);
        clear_log();
        pulse_start();
        load_t1_frame(8'h9F);
        send_frame(1'b0);
        wait_idle("t6_wait");
        check("t6_nwr2",  wa.size(), 2);
        check("t6_a0",    wa[0], 8'h00);
        check("t6_d0",    wd[0], 12'hA15);
        check("t6_flags", {busy, done, error}, 3'b010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pmem_stream_loader.md
Name: pmem_stream_loader

Overview:
- Producer side of the program-memory load interface used during the LOAD stage.
- Accepts a framed byte stream over a valid/ready handshake and packs byte pairs into 12-bit instruction words.
- Writes each word into program memory with a write-enable strobe, validates a trailing XOR checksum, and reports done or error.
- While it is busy, the core's stage sequencer holds the LOAD stage; on done it releases to FETCH.

Parameters:
- ADDR_W, 8, program-memory address width. Depth is 2**ADDR_W words.
- INSTR_W, 12, instruction width. Fixed at 12; other values are unsupported.
- START_ADDR, 0, first program-memory address written by each load.

Ports:
- clk, input, 1, system clock. Rising edge.
- rst_n, input, 1, reset. Asynchronous, active-low.
- start, input, 1, one-cycle pulse that begins a load. Ignored while busy=1.
- in_data, input, 8, stream byte.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, loader can accept a byte this cycle.
- pmem_addr, output, ADDR_W, write address.
- pmem_wdata, output, INSTR_W, write data.
- pmem_we, output, 1, one-cycle write strobe. Drives the program-memory load enable.
- busy, output, 1, load in progress. Stage sequencer holds LOAD while high.
- done, output, 1, sticky: last load completed with a good checksum.
- error, output, 1, sticky: last load failed.

Behaviour:
- Reset values: in_ready=0, pmem_addr=START_ADDR, pmem_wdata=0, pmem_we=0, busy=0, done=0, error=0. State is IDLE.
- Reset is asynchronous. Asserting it mid-load aborts immediately. Words already written stay in memory; no further writes occur.
- A byte transfers on a rising edge only when in_valid=1 and in_ready=1.
- in_ready=1 exactly in states HDR, HI, LO and CHK.
- Frame format: count byte N, then N word pairs, then a checksum byte.
  - N=0 means 2**ADDR_W words.
  - Each word pair is a hi byte giving word[11:4], then a lo byte whose [3:0] gives word[3:0] and whose [7:4] must be 0.
  - The checksum byte equals the XOR of every byte after the count byte, excluding the checksum byte itself.
- IDLE:
  - start=1 moves to HDR next cycle.
  - Also on start: busy←1, done←0, error←0, pmem_addr←START_ADDR, running XOR←0, word counter←0.
- HDR: on transfer, latch N and go to HI.
- HI: on transfer, hold the byte, XOR it into the running checksum, go to LO.
- LO, on transfer with lo[7:4]≠0: go to ERR.
- LO, on transfer with lo[7:4]=0:
  - XOR the byte in and assemble the word.
  - Next cycle: pmem_we=1 for exactly one cycle, pmem_wdata=word, pmem_addr=current address.
  - In the cycle after the strobe, pmem_addr increments. It wraps modulo 2**ADDR_W.
  - Word counter increments. Go to CHK if counter==N (N=0 means 2**ADDR_W), else HI.
- Latency: pmem_we rises 1 cycle after the lo-byte transfer. pmem_addr and pmem_wdata are stable during the strobe.
- Back-to-back streaming sustains one byte per cycle. pmem_we never asserts on two consecutive cycles.
- CHK: on transfer, compare the byte with the running XOR. Equal goes to DONE; unequal goes to ERR.
- DONE: busy←0, done←1, return to IDLE.
- ERR: busy←0, error←1, return to IDLE.
- done and error are mutually exclusive. Both hold until the next accepted start or reset.
- in_valid=0 in any receive state simply stalls; there is no timeout.
- start while busy=1 has no effect. start in the same cycle as DONE/ERR completion is ignored. start is only sampled in IDLE.
- Bytes presented in IDLE are not accepted (in_ready=0).

Test Plan:
- Reset then start; stream 02, A1, 05, 3C, 07, XOR=A1^05^3C^07=9F.
  - Expect two pmem_we pulses: addr 0 data 0xA15, addr 1 data 0x3C7.
  - Then done=1, busy=0, error=0.
- Same frame with checksum byte 00.
  - Expect both words written, then error=1, done=0.
- Frame 01, FF, 1F.
  - Expect error=1 immediately after the lo byte, with no pmem_we pulse and in_ready=0 afterwards.
- Count byte 00 with 256 word pairs streamed continuously.
  - Expect 256 strobes at addresses 0..255, pmem_addr wrapping to 0, then done=1.
  - Expect a strobe every second cycle.
- Valid load with in_valid toggling randomly, plus a start pulse mid-frame.
  - Expect identical writes and done=1; the second start is ignored.
- Assert rst_n low after the first word is written.
  - Expect all outputs at reset values within the same cycle, no further pmem_we, and a subsequent start to load from START_ADDR.
